// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: words, ALU op encodings and nzp condition codes.
// Also provides the CC helper used by every unit that writes a register result.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_cc;

  // Encoding 3'd7 is left undefined; functional units treat it as a pass.
  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  function automatic lc3b_cc gen_cc(input lc3b_word r);
    lc3b_cc cc;
    cc       = '0;
    cc[CC_N] = r[15];
    cc[CC_Z] = (r == 16'h0000);
    cc[CC_P] = ~r[15] & (r != 16'h0000);
    return cc;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational LC-3b integer datapath (aluop, a, b -> result); zero latency.
// No state and no handshake, so it carries no backpressure of its own.
module alu
  import lc3b_types::*;
(
  input  lc3b_aluop aluop,
  input  lc3b_word  a,
  input  lc3b_word  b,
  output lc3b_word  result
);

  logic [3:0] shamt;
  assign shamt = b[3:0];

  always_comb begin
    result = a;
    case (aluop)
      alu_add:  result = a + b;
      alu_and:  result = a & b;
      alu_not:  result = ~a;
      alu_pass: result = a;
      alu_sll:  result = a << shamt;
      alu_srl:  result = a >> shamt;
      alu_sra:  result = lc3b_word'($signed(a) >>> shamt);
      default:  result = a;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU functional unit with an in-order result buffer draining onto the CDB; issue to cdb_req is 1 cycle.
// Backpressure: issue_ready drops when the buffer is full unless the head is granted the same cycle.
module alu_exec_unit
  import lc3b_types::*;
#(
  parameter int TAG_W = 3,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  lc3b_aluop                issue_aluop,
  input  lc3b_word                 issue_srca,
  input  lc3b_word                 issue_srcb,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     cdb_req,
  input  logic                     cdb_grant,
  output lc3b_word                 cdb_value,
  output lc3b_cc                   cdb_cc,
  output logic [TAG_W-1:0]         cdb_tag,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    lc3b_cc           cc;
    lc3b_word         value;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_q;
  entry_t             new_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  lc3b_word           alu_result;
  logic               do_push;
  logic               do_pop;

  alu u_alu (
    .aluop  (issue_aluop),
    .a      (issue_srca),
    .b      (issue_srcb),
    .result (alu_result)
  );

  assign new_entry   = '{tag: issue_tag, cc: gen_cc(alu_result), value: alu_result};
  assign cdb_req     = (count_q != '0);
  assign issue_ready = (count_q < CNT_W'(DEPTH)) | (cdb_grant & cdb_req);
  assign do_push     = issue_valid & issue_ready & ~flush;
  assign do_pop      = cdb_grant & cdb_req & ~flush;

  // head_q is a registered copy of the buffer head so the CDB outputs hold
  // their last value once the buffer empties instead of exposing stale slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (do_pop) begin
        if (count_q > CNT_W'(1))  head_q <= mem[rd_ptr + PTR_W'(1)];
        else if (do_push)         head_q <= new_entry;
      end else if ((count_q == '0) && do_push) begin
        head_q <= new_entry;
      end
    end
  end

  assign cdb_value = head_q.value;
  assign cdb_cc    = head_q.cc;
  assign cdb_tag   = head_q.tag;
  assign count     = count_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Integer functional unit consuming the `lc3b_aluop` produced by the decode-side ALU control logic. It accepts one issued operation per cycle from the ALU reservation station, computes the result and condition codes, and holds finished results in a 2-entry in-order buffer. The buffer drains onto the common data bus (CDB) under arbiter grant. It sits between the ALU reservation station and the CDB arbiter in the out-of-order core.

## Interface
Parameters:
- `TAG_W`, 3: ROB tag width.
- `DEPTH`, 2: result buffer entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `issue_valid`  in  1  reservation station presents an operation.
- `issue_ready`  out  1  unit can accept this cycle.
- `issue_aluop`  in  `lc3b_aluop`  operation select.
- `issue_srca`  in  16  operand A (`lc3b_word`).
- `issue_srcb`  in  16  operand B, or immediate/shift amount already formed.
- `issue_tag`  in  TAG_W  destination ROB tag.
- `cdb_req`  out  1  buffer head is valid.
- `cdb_grant`  in  1  arbiter takes the head this cycle. Only meaningful while `cdb_req` is high.
- `cdb_value`  out  16  head result.
- `cdb_cc`  out  3  head condition codes {n,z,p}.
- `cdb_tag`  out  TAG_W  head tag.
- `flush`  in  1  mispredict/exception squash.
- `count`  out  $clog2(DEPTH)+1  occupied entries (debug/perf).

## Operation
- Accept: `issue_valid & issue_ready & ~flush` at an edge writes one entry at the tail.
- Result is computed combinationally from the issue operands and registered into the entry:
  - `alu_add`: srca+srcb, mod 2^16.
  - `alu_and`: srca&srcb.
  - `alu_not`: ~srca.
  - `alu_pass`: srca.
  - `alu_sll`: srca << srcb[3:0].
  - `alu_srl`: logical right shift by srcb[3:0].
  - `alu_sra`: arithmetic right shift by srcb[3:0].
  - Any undefined encoding: behaves as `alu_pass`.
- CC from the 16-bit result:
  - n = result[15].
  - z = (result == 0).
  - p = ~n & ~z.
  - Exactly one bit is set.
- `issue_ready = (count < DEPTH) | (cdb_grant & cdb_req)`. Same-cycle drain frees a slot.
- Drain: `cdb_grant & cdb_req` at an edge pops the head. `cdb_*` then show the next entry, or hold their last value with `cdb_req` low.
- Accept and grant in the same cycle: count unchanged; new entry goes to the tail. With count 0, no bypass: a new op is not visible until the next cycle.
- `flush` at an edge:
  - Empties the buffer (count→0, pointers reset).
  - Discards any same-cycle accept and ignores any same-cycle grant.
  - `issue_ready` stays at its formula value; the reservation station is flushed in parallel.
- Buffer order is strictly FIFO. Pointers wrap modulo DEPTH.
- Grant with `cdb_req` low is ignored (no underflow).
- Issue with `issue_ready` low is ignored and the operation is not captured. The station must hold it.

## Timing
- Latency: accept at edge N → `cdb_req` high after edge N, i.e. available for grant in cycle N+1. Minimum issue-to-broadcast latency is 1 cycle.
- Throughput: one op per cycle sustained while granted every cycle.
- `cdb_*` outputs come from registers/buffer read, with no path from issue inputs.
- The only combinational input→output path is `cdb_grant` → `issue_ready`.
- Reset (async assert, sync deassert external):
  - count=0, `cdb_req`=0, `issue_ready`=1.
  - `cdb_value`=0, `cdb_cc`=3'b000, `cdb_tag`=0.
  - Pointers=0.
- Reset mid-operation drops all buffered results without broadcast.

## Structure
- `lc3b_aluop`, `lc3b_word` and a new `lc3b_cc` (3-bit nzp) typedef live in `lc3b_types`. CC bit positions are package constants.
- Sub-module: `alu`, a purely combinational datapath (aluop, a, b → result). It is instantiated once and reusable by address-generation units.
- The FIFO and handshake are in `alu_exec_unit` itself.

## Test plan
- Reset, then issue add 0x7FFF+0x0001, tag 3, grant next cycle → `cdb_value`=0x8000, cc=100, tag=3, `cdb_req` high exactly one cycle after accept.
- sra 0x8004 by 2, srl 0x8004 by 2, sll 0x0001 by 15, grant held high → values 0xE001, 0x2001, 0x8000 broadcast in order on consecutive cycles. Undefined aluop with srca 0x1234 → 0x1234, cc=001.
- Grant low, issue 3 ops back-to-back → first two accepted, `issue_ready` low in cycle 3, count=2. Raise grant → third accepted that same cycle, count stays 2.
- and 0x00FF & 0xFF00 → value 0, cc=010. not 0x0000 → 0xFFFF, cc=100.
- Buffer full, assert flush with simultaneous issue and grant → count=0 next cycle, `cdb_req` low, no broadcast of the flushed or newly issued tags.
- Assert `rst_n` low asynchronously mid-cycle with 2 entries → outputs reach reset values before the next edge. After release, normal issue works.
